id_ex_stage: RTL and testbench

ID/EX pipeline stage that sits directly downstream of the register file. It captures the two register read operands together with the decoded instruction fields and presents them to the execute stage one cycle later. The block applies a valid/ready handshake and honours a flush from branch resolution. It also detects load-use hazards and inserts bubbles for them.

---
 rtl/id_ex_stage.sv | 170 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush, load-use bubble insertion
// and a saturating stall counter. Define WB_FORWARD_EN to bypass writeback data into the operands.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [RA_W-1:0]   id_rs1,
    input  logic [RA_W-1:0]   id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [RA_W-1:0]   id_rd,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_mem_read,
    input  logic [XLEN-1:0]   rf_data1,
    input  logic [XLEN-1:0]   rf_data2,
    input  logic              wb_regwrite,
    input  logic [RA_W-1:0]   wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_op1,
    output logic [XLEN-1:0]   ex_op2,
    output logic [RA_W-1:0]   ex_rs1,
    output logic [RA_W-1:0]   ex_rs2,
    output logic [RA_W-1:0]   ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_mem_read,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              ex_valid_q,    ex_valid_d;
    logic [XLEN-1:0]   ex_pc_q,       ex_pc_d;
    logic [XLEN-1:0]   ex_imm_q,      ex_imm_d;
    logic [XLEN-1:0]   ex_op1_q,      ex_op1_d;
    logic [XLEN-1:0]   ex_op2_q,      ex_op2_d;
    logic [RA_W-1:0]   ex_rs1_q,      ex_rs1_d;
    logic [RA_W-1:0]   ex_rs2_q,      ex_rs2_d;
    logic [RA_W-1:0]   ex_rd_q,       ex_rd_d;
    logic [CTRL_W-1:0] ex_ctrl_q,     ex_ctrl_d;
    logic              ex_mem_read_q, ex_mem_read_d;
    logic [CNT_W-1:0]  stall_cnt_q,   stall_cnt_d;

    logic load;
    logic hz;

    logic [RA_W-1:0] src_rs [2];
    logic [XLEN-1:0] src_rf [2];
    logic [XLEN-1:0] op_sel [2];

    assign src_rs[0] = id_rs1;
    assign src_rs[1] = id_rs2;
    assign src_rf[0] = rf_data1;
    assign src_rf[1] = rf_data2;

    // x0 always reads as zero, whatever the register file or writeback presents
    for (genvar gi = 0; gi < 2; gi++) begin : g_opsel
`ifdef WB_FORWARD_EN
        logic fwd;
        assign fwd = wb_regwrite && (wb_rd != '0) && (wb_rd == src_rs[gi]);
        assign op_sel[gi] = (src_rs[gi] == '0) ? '0 : (fwd ? wb_data : src_rf[gi]);
`else
        assign op_sel[gi] = (src_rs[gi] == '0) ? '0 : src_rf[gi];
`endif
    end

`ifndef WB_FORWARD_EN
    logic unused_wb;
    assign unused_wb = ^{wb_regwrite, wb_rd, wb_data};
`endif

    always_comb begin
        load = ex_ready | ~ex_valid_q;
        hz   = ex_valid_q & ex_mem_read_q & (ex_rd_q != '0) &
               ((id_use_rs1 & (ex_rd_q == id_rs1)) | (id_use_rs2 & (ex_rd_q == id_rs2)));
        id_ready = load & ~hz & ~flush;
    end

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_pc_d       = ex_pc_q;
        ex_imm_d      = ex_imm_q;
        ex_op1_d      = ex_op1_q;
        ex_op2_d      = ex_op2_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        ex_rd_d       = ex_rd_q;
        ex_ctrl_d     = ex_ctrl_q;
        ex_mem_read_d = ex_mem_read_q;
        stall_cnt_d   = stall_cnt_q;

        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (load) begin
            if (hz) begin
                // bubble must not look like a load, or it would stall the next instruction
                ex_valid_d    = 1'b0;
                ex_mem_read_d = 1'b0;
            end else begin
                ex_valid_d = id_valid;
                ex_pc_d    = id_pc;
                ex_imm_d   = id_imm;
                ex_op1_d   = op_sel[0];
                ex_op2_d   = op_sel[1];
                ex_rs1_d   = id_rs1;
                ex_rs2_d   = id_rs2;
                if (id_valid) begin
                    ex_rd_d       = id_rd;
                    ex_ctrl_d     = id_ctrl;
                    ex_mem_read_d = id_mem_read;
                end
            end
        end

        if (id_valid && hz && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_imm_q      <= '0;
            ex_op1_q      <= '0;
            ex_op2_q      <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_ctrl_q     <= '0;
            ex_mem_read_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_imm_q      <= ex_imm_d;
            ex_op1_q      <= ex_op1_d;
            ex_op2_q      <= ex_op2_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_rd_q       <= ex_rd_d;
            ex_ctrl_q     <= ex_ctrl_d;
            ex_mem_read_q <= ex_mem_read_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_pc       = ex_pc_q;
    assign ex_imm      = ex_imm_q;
    assign ex_op1      = ex_op1_q;
    assign ex_op2      = ex_op2_q;
    assign ex_rs1      = ex_rs1_q;
    assign ex_rs2      = ex_rs2_q;
    assign ex_rd       = ex_rd_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign ex_mem_read = ex_mem_read_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: vector table through a scoreboard queue, then hand-written
// load-use, back-pressure, flush, saturation and asynchronous reset sequences.
module tb_id_ex_stage;

    localparam int XLEN   = 32;
    localparam int RA_W   = 5;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;
`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid, id_ready;
    logic [XLEN-1:0]   id_pc, id_imm;
    logic [RA_W-1:0]   id_rs1, id_rs2, id_rd;
    logic              id_use_rs1, id_use_rs2, id_mem_read;
    logic [CTRL_W-1:0] id_ctrl;
    logic [XLEN-1:0]   rf_data1, rf_data2;
    logic              wb_regwrite;
    logic [RA_W-1:0]   wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              flush, ex_ready, ex_valid, ex_mem_read;
    logic [XLEN-1:0]   ex_pc, ex_imm, ex_op1, ex_op2;
    logic [RA_W-1:0]   ex_rs1, ex_rs2, ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]  stall_cnt;

    id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl), .id_mem_read(id_mem_read),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .ex_mem_read(ex_mem_read), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            vld;
        logic [31:0]     pc;
        logic [RA_W-1:0] rs1, rs2;
        logic [31:0]     rf1, rf2;
        logic            wbw;
        logic [RA_W-1:0] wbrd;
        logic [31:0]     wbdata;
        logic [31:0]     e1, e2;
    } vec_t;

    typedef struct {
        logic            vld;
        logic [31:0]     pc, op1, op2;
        logic [RA_W-1:0] rs1, rs2, rd;
        logic            mr;
    } exp_t;

    exp_t sb[$];
    vec_t vecs [7];
    int   n_checks = 0;
    int   n_errors = 0;
    int   txn = 0;
    int   stall_exp = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic vld, input logic [31:0] pc,
                          input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2,
                          input logic [RA_W-1:0] rd, input logic [31:0] rf1,
                          input logic [31:0] rf2, input logic mr);
        id_valid    = vld;
        id_pc       = pc;
        id_imm      = pc ^ 32'hA5A5_0000;
        id_ctrl     = pc[7:0];
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_use_rs1  = 1'b1;
        id_use_rs2  = 1'b1;
        id_rd       = rd;
        id_mem_read = mr;
        rf_data1    = rf1;
        rf_data2    = rf2;
    endtask

    task automatic push_exp(input logic [31:0] op1, input logic [31:0] op2);
        exp_t e;
        e.vld = id_valid; e.pc = id_pc; e.op1 = op1; e.op2 = op2;
        e.rs1 = id_rs1; e.rs2 = id_rs2; e.rd = id_rd; e.mr = id_mem_read;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        txn++;
        $display("txn %0d: pc=0x%0h valid=%0b op1=0x%0h op2=0x%0h", txn, ex_pc, ex_valid, ex_op1, ex_op2);
        check("ex_valid", {63'd0, ex_valid}, {63'd0, e.vld});
        if (e.vld) begin
            check("ex_pc",       {32'd0, ex_pc},  {32'd0, e.pc});
            check("ex_op1",      {32'd0, ex_op1}, {32'd0, e.op1});
            check("ex_op2",      {32'd0, ex_op2}, {32'd0, e.op2});
            check("ex_imm",      {32'd0, ex_imm}, {32'd0, e.pc ^ 32'hA5A5_0000});
            check("ex_ctrl",     {56'd0, ex_ctrl}, {56'd0, e.pc[7:0]});
            check("ex_rs",       {54'd0, ex_rs1, ex_rs2}, {54'd0, e.rs1, e.rs2});
            check("ex_rd",       {59'd0, ex_rd}, {59'd0, e.rd});
            check("ex_mem_read", {63'd0, ex_mem_read}, {63'd0, e.mr});
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);

        vecs[0] = '{1'b1, 32'h100, 5'd1, 5'd2, 32'd10,     32'd2,    1'b0, 5'd0, 32'h0,    32'd10,    32'd2};
        vecs[1] = '{1'b1, 32'h104, 5'd0, 5'd4, 32'hFFFF,   32'd7,    1'b0, 5'd0, 32'h0,    32'd0,     32'd7};
        vecs[2] = '{1'b1, 32'h108, 5'd6, 5'd3, 32'h1234,   32'd3,    1'b1, 5'd3, 32'h55,   32'h1234,  FWD ? 32'h55 : 32'd3};
        vecs[3] = '{1'b1, 32'h10C, 5'd3, 5'd0, 32'h77,     32'hEE,   1'b0, 5'd3, 32'h99,   32'h77,    32'd0};
        vecs[4] = '{1'b0, 32'h110, 5'd1, 5'd2, 32'h1,      32'h2,    1'b0, 5'd0, 32'h0,    32'h0,     32'h0};
        vecs[5] = '{1'b1, 32'h114, 5'd0, 5'd9, 32'h5,      32'h9,    1'b1, 5'd0, 32'hDEAD, 32'd0,     32'h9};
        vecs[6] = '{1'b1, 32'h118, 5'd9, 5'd9, 32'hAB,     32'hAB,   1'b1, 5'd9, 32'hCD,   FWD ? 32'hCD : 32'hAB, FWD ? 32'hCD : 32'hAB};

        tick(); tick();
        check("rst_ex_valid",  {63'd0, ex_valid}, 64'd0);
        check("rst_stall_cnt", {60'd0, stall_cnt}, 64'd0);
        check("rst_ex_pc",     {32'd0, ex_pc}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // table-driven captures, ex_ready held high, no loads in flight
        for (int i = 0; i < 7; i++) begin
            set_id(vecs[i].vld, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, 5'(i + 10),
                   vecs[i].rf1, vecs[i].rf2, 1'b0);
            wb_regwrite = vecs[i].wbw; wb_rd = vecs[i].wbrd; wb_data = vecs[i].wbdata;
            #1;
            check("vec_id_ready", {63'd0, id_ready}, 64'd1);
            push_exp(vecs[i].e1, vecs[i].e2);
            tick();
            pop_check();
        end
        wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;

        // load-use: load rd=5 then consumer of x5 on rs1
        set_id(1'b1, 32'h200, 5'd1, 5'd2, 5'd5, 32'h11, 32'h22, 1'b1);
        #1; check("lu_load_ready", {63'd0, id_ready}, 64'd1);
        push_exp(32'h11, 32'h22);
        tick(); pop_check();
        set_id(1'b1, 32'h204, 5'd5, 5'd0, 5'd6, 32'h33, 32'h0, 1'b0);
        #1; check("lu_ready_low", {63'd0, id_ready}, 64'd0);
        tick(); stall_exp = 1;
        check("lu_bubble_valid", {63'd0, ex_valid}, 64'd0);
        check("lu_bubble_mr",    {63'd0, ex_mem_read}, 64'd0);
        check("lu_stall_cnt",    {60'd0, stall_cnt}, 64'(stall_exp));
        check("lu_ready_high",   {63'd0, id_ready}, 64'd1);
        push_exp(32'h33, 32'h0);
        tick(); pop_check();

        // back-pressure: three held cycles then release
        set_id(1'b1, 32'h300, 5'd1, 5'd2, 5'd8, 32'hA, 32'hB, 1'b0);
        #1; push_exp(32'hA, 32'hB);
        tick(); pop_check();
        ex_ready = 1'b0;
        set_id(1'b1, 32'h304, 5'd3, 5'd4, 5'd9, 32'hC, 32'hD, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1; check("bp_ready_low", {63'd0, id_ready}, 64'd0);
            tick();
            check("bp_hold_pc",    {32'd0, ex_pc}, 64'h300);
            check("bp_hold_op1",   {32'd0, ex_op1}, 64'hA);
            check("bp_hold_valid", {63'd0, ex_valid}, 64'd1);
        end
        ex_ready = 1'b1;
        #1; check("bp_release_ready", {63'd0, id_ready}, 64'd1);
        push_exp(32'hC, 32'hD);
        tick(); pop_check();

        // flush with back-pressure while a load in EX would otherwise cause a stall
        set_id(1'b1, 32'h400, 5'd1, 5'd2, 5'd7, 32'h1, 32'h2, 1'b1);
        #1; push_exp(32'h1, 32'h2);
        tick(); pop_check();
        ex_ready = 1'b0; flush = 1'b1;
        set_id(1'b1, 32'h404, 5'd7, 5'd0, 5'd1, 32'h3, 32'h0, 1'b0);
        #1; check("fl_ready_low", {63'd0, id_ready}, 64'd0);
        tick();
        check("fl_ex_valid",  {63'd0, ex_valid}, 64'd0);
        check("fl_stall_cnt", {60'd0, stall_cnt}, 64'(stall_exp));
        flush = 1'b0; ex_ready = 1'b1;

        // saturation: load stays in EX, rs2 consumer stalls for 20 cycles
        set_id(1'b1, 32'h500, 5'd1, 5'd2, 5'd7, 32'h1, 32'h2, 1'b1);
        #1; push_exp(32'h1, 32'h2);
        tick(); pop_check();
        ex_ready = 1'b0;
        set_id(1'b1, 32'h504, 5'd0, 5'd7, 5'd1, 32'h0, 32'h4, 1'b0);
        for (int k = 0; k < 20; k++) begin
            tick();
            stall_exp = (stall_exp < 15) ? stall_exp + 1 : 15;
            check("sat_stall_cnt", {60'd0, stall_cnt}, 64'(stall_exp));
        end
        check("sat_ex_pc", {32'd0, ex_pc}, 64'h500);

        // unused source does not stall; then capture PC 0x40 and reset mid-stream
        ex_ready = 1'b1;
        set_id(1'b1, 32'h40, 5'd7, 5'd0, 5'd1, 32'h1, 32'h2, 1'b0);
        id_use_rs1 = 1'b0;
        #1; check("nouse_ready", {63'd0, id_ready}, 64'd1);
        push_exp(32'h1, 32'h0);
        tick(); pop_check();
        #2 rst_n = 1'b0;
        #1;
        check("arst_ex_valid",  {63'd0, ex_valid}, 64'd0);
        check("arst_stall_cnt", {60'd0, stall_cnt}, 64'd0);
        check("arst_ex_pc",     {32'd0, ex_pc}, 64'd0);
        check("arst_ex_mr",     {63'd0, ex_mem_read}, 64'd0);
        check("sb_drained",     64'(sb.size()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
